cv32e40x_instr_obi_outstanding_if: RTL and testbench
====================================================

CV32E40X_INSTR_OBI_OUTSTANDING_IF -- requirements
Module: cv32e40x_instr_obi_outstanding_if

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max granted-but-unanswered OBI transactions (legal 1..8).
REQ-002 SHALL have ports:
 clk  input  1  single clock, all state on rising edge
 rst  input  1  synchronous active-high reset
 trans_valid_i  input  1  fetch request valid
 trans_ready_o  output  1  fetch request accepted when valid&ready
 trans_addr_i  input  32  fetch address
 trans_prot_i  input  3  fetch protection attributes
 kill_i  input  1  flush; discard all responses of pre-kill transactions
 resp_valid_o  output  1  response to consumer (consumer always ready)
 resp_rdata_o  output  32  response data
 resp_err_o  output  1  response bus error
 obi_req_o  output  1  OBI A-channel request
 obi_gnt_i  input  1  OBI grant
 obi_addr_o  output  32  OBI address
 obi_prot_o  output  3  OBI prot
 obi_rvalid_i  input  1  OBI R-channel valid
 obi_rdata_i  input  32  OBI read data
 obi_err_i  input  1  OBI error
 outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current outstanding count
 idle_o  output  1  no outstanding and no pending request

Function
REQ-003 SHALL keep FSM states TRANSPARENT, REGISTERED; reset state TRANSPARENT.
REQ-004 TRANSPARENT: obi_req_o = trans_valid_i & cnt<MAX_OUTSTANDING & !kill_i; obi_addr_o/obi_prot_o = trans_addr_i/trans_prot_i.
REQ-005 TRANSPARENT -> REGISTERED when obi_req_o & !obi_gnt_i; addr/prot captured into registers that cycle.
REQ-006 REGISTERED: obi_req_o = 1 (never retracted, also during kill_i), addr/prot from registers; -> TRANSPARENT on obi_gnt_i.
REQ-007 trans_ready_o = (state==TRANSPARENT) & cnt<MAX_OUTSTANDING & !kill_i; combinational, no dependency on obi_gnt_i.
REQ-008 cnt: +1 on obi_req_o&obi_gnt_i, -1 on obi_rvalid_i, unchanged when both; never exceeds MAX_OUTSTANDING nor wraps below 0.
REQ-009 obi_rvalid_i with cnt==0 is a protocol violation; cnt SHALL saturate at 0 (assertion flags it).
REQ-010 kill_i cycle: resp_valid_o=0; drop_cnt <= cnt - obi_rvalid_i + (obi_req_o&obi_gnt_i); kill_pend <= (state==REGISTERED)&!obi_gnt_i.
REQ-011 kill_pend set & obi_gnt_i: drop_cnt += 1 (minus rvalid same cycle), kill_pend cleared.
REQ-012 drop_cnt>0 & obi_rvalid_i: response suppressed (resp_valid_o=0), drop_cnt -= 1.
REQ-013 Otherwise resp_valid_o = obi_rvalid_i, resp_rdata_o = obi_rdata_i, resp_err_o = obi_err_i, zero latency.
REQ-014 kill_i while drop_cnt>0 SHALL recompute per REQ-010 (drop_cnt <= cnt always holds).
REQ-015 idle_o = (cnt==0) & (state==TRANSPARENT) & !kill_pend.
REQ-016 outstanding_o = cnt (registered value).

Reset
REQ-017 rst high: state TRANSPARENT, cnt=0, drop_cnt=0, kill_pend=0, addr/prot registers 0, next cycle.
REQ-018 During/after reset: obi_req_o=0 unless trans_valid_i, resp_valid_o follows obi_rvalid_i, trans_ready_o=1, idle_o=1, outstanding_o=0.
REQ-019 Reset mid-transaction drops all tracking; bus-side quiescence is system responsibility.

Structure
REQ-020 FSM enum reuses obi_if_state_e from cv32e40x_pkg; no new package typedefs.
REQ-021 Counter widths derived locally from MAX_OUTSTANDING; no sub-module.
REQ-022 Elaboration-time assertion SHALL reject MAX_OUTSTANDING outside 1..8.

Verification
REQ-023 MAX=2, gnt always 1, rvalid delayed 3 cycles: 3rd request sees trans_ready_o=0, outstanding_o=2, resumes after first rvalid.
REQ-024 gnt low 4 cycles, trans_addr_i changes 0x100->0x200: obi_addr_o held 0x100, obi_req_o=1 until gnt.
REQ-025 2 outstanding, kill_i 1 cycle, new fetch 0x400: first 2 rvalids suppressed, 3rd (0x400) delivered.
REQ-026 kill_i in REGISTERED, gnt 2 cycles later: that transaction's response also suppressed, drop_cnt returns 0, idle_o=1.
REQ-027 Same cycle gnt+rvalid at cnt=1: cnt stays 1; rst mid-flight -> outstanding_o=0, idle_o=1 next cycle.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared core definitions used by the instruction-side OBI interface.
package cv32e40x_pkg;

    typedef enum logic [0:0] {
        TRANSPARENT = 1'b0,
        REGISTERED  = 1'b1
    } obi_if_state_e;

endpackage

// File: rtl/cv32e40x_instr_obi_outstanding_if.sv
// Instruction fetch OBI interface: keeps address phase stable while ungranted,
// tracks outstanding transactions and drops responses belonging to killed fetches.
module cv32e40x_instr_obi_outstanding_if
    import cv32e40x_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       trans_valid_i,
    output logic                                       trans_ready_o,
    input  logic [31:0]                                trans_addr_i,
    input  logic [2:0]                                 trans_prot_i,
    input  logic                                       kill_i,
    output logic                                       resp_valid_o,
    output logic [31:0]                                resp_rdata_o,
    output logic                                       resp_err_o,
    output logic                                       obi_req_o,
    input  logic                                       obi_gnt_i,
    output logic [31:0]                                obi_addr_o,
    output logic [2:0]                                 obi_prot_o,
    input  logic                                       obi_rvalid_i,
    input  logic [31:0]                                obi_rdata_i,
    input  logic                                       obi_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
    output logic                                       idle_o
);

    localparam int unsigned    CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    if ((MAX_OUTSTANDING == 0) || (MAX_OUTSTANDING > 8)) begin : g_param_check
        $error("MAX_OUTSTANDING must be within 1..8");
    end

    obi_if_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             kill_pend_q, kill_pend_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       prot_q, prot_d;
    logic             cnt_full;
    logic             granted;
    logic             drop_rvalid;

    // Address phase, handshake and response forwarding
    always_comb begin
        cnt_full      = (cnt_q >= CNT_MAX);
        trans_ready_o = (state_q == TRANSPARENT) && !cnt_full && !kill_i;
        obi_req_o     = trans_valid_i && !cnt_full && !kill_i;
        obi_addr_o    = trans_addr_i;
        obi_prot_o    = trans_prot_i;
        if (state_q == REGISTERED) begin
            obi_req_o  = 1'b1;
            obi_addr_o = addr_q;
            obi_prot_o = prot_q;
        end
        granted       = obi_req_o && obi_gnt_i;
        drop_rvalid   = obi_rvalid_i && (drop_q != '0);
        resp_valid_o  = obi_rvalid_i && !kill_i && (drop_q == '0);
        resp_rdata_o  = obi_rdata_i;
        resp_err_o    = obi_err_i;
        idle_o        = (cnt_q == '0) && (state_q == TRANSPARENT) && !kill_pend_q;
        outstanding_o = cnt_q;
    end

    // Next-state: FSM, outstanding counter and kill bookkeeping
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        prot_d      = prot_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        kill_pend_d = kill_pend_q;

        case (state_q)
            TRANSPARENT: begin
                if (obi_req_o && !obi_gnt_i) begin
                    state_d = REGISTERED;
                    addr_d  = trans_addr_i;
                    prot_d  = trans_prot_i;
                end
            end
            REGISTERED: begin
                if (obi_gnt_i) begin
                    state_d = TRANSPARENT;
                end
            end
            default: state_d = TRANSPARENT;
        endcase

        if (granted && !obi_rvalid_i) begin
            if (!cnt_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!granted && obi_rvalid_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // Everything in flight at kill time (including a still-ungranted request) must be discarded
        if (kill_i) begin
            drop_d      = cnt_d;
            kill_pend_d = (state_q == REGISTERED) && !obi_gnt_i;
        end else begin
            if (kill_pend_q && obi_gnt_i) begin
                drop_d      = drop_d + CNT_W'(1);
                kill_pend_d = 1'b0;
            end
            if (drop_rvalid) begin
                drop_d = drop_d - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TRANSPARENT;
            cnt_q       <= '0;
            drop_q      <= '0;
            kill_pend_q <= 1'b0;
            addr_q      <= '0;
            prot_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            kill_pend_q <= kill_pend_d;
            addr_q      <= addr_d;
            prot_q      <= prot_d;
        end
    end

    a_rvalid_without_outstanding: assert property (
        @(posedge clk) disable iff (rst) !(obi_rvalid_i && (cnt_q == '0))
    ) else $error("obi_rvalid_i received with no outstanding transaction");

endmodule

// File: tb/tb_cv32e40x_instr_obi_outstanding_if.sv
// Directed self-checking bench for the instruction OBI outstanding interface (MAX_OUTSTANDING=2).
module tb_cv32e40x_instr_obi_outstanding_if;

    logic        clk;
    logic        rst;
    logic        trans_valid_i;
    logic        trans_ready_o;
    logic [31:0] trans_addr_i;
    logic [2:0]  trans_prot_i;
    logic        kill_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic [2:0]  obi_prot_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic [1:0]  outstanding_o;
    logic        idle_o;

    int n_cmp;
    int n_err;

    cv32e40x_instr_obi_outstanding_if #(.MAX_OUTSTANDING(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .trans_valid_i (trans_valid_i),
        .trans_ready_o (trans_ready_o),
        .trans_addr_i  (trans_addr_i),
        .trans_prot_i  (trans_prot_i),
        .kill_i        (kill_i),
        .resp_valid_o  (resp_valid_o),
        .resp_rdata_o  (resp_rdata_o),
        .resp_err_o    (resp_err_o),
        .obi_req_o     (obi_req_o),
        .obi_gnt_i     (obi_gnt_i),
        .obi_addr_o    (obi_addr_o),
        .obi_prot_o    (obi_prot_o),
        .obi_rvalid_i  (obi_rvalid_i),
        .obi_rdata_i   (obi_rdata_i),
        .obi_err_i     (obi_err_i),
        .outstanding_o (outstanding_o),
        .idle_o        (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are settled 1 time unit later
    task automatic drive(input logic valid, input logic [31:0] addr, input logic gnt,
                         input logic rv, input logic [31:0] rdata, input logic kill);
        trans_valid_i = valid;
        trans_addr_i  = addr;
        obi_gnt_i     = gnt;
        obi_rvalid_i  = rv;
        obi_rdata_i   = rdata;
        kill_i        = kill;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst          = 1'b1;
        trans_prot_i = 3'b101;
        obi_err_i    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();

        // Reset state, response path still follows rvalid
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        check_eq("rst_outstanding", 32'(outstanding_o), 32'd0);
        check_eq("rst_idle",        32'(idle_o),        32'd1);
        check_eq("rst_ready",       32'(trans_ready_o), 32'd1);
        check_eq("rst_req",         32'(obi_req_o),     32'd0);
        check_eq("rst_resp_valid",  32'(resp_valid_o),  32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        tick();

        // Back-pressure at MAX_OUTSTANDING, gnt always high, rvalid 3 cycles after grant
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("a_ready", 32'(trans_ready_o), 32'd1);
        check_eq("a_addr",  obi_addr_o,         32'h10);
        check_eq("a_prot",  32'(obi_prot_o),    32'h5);
        tick();
        drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("b_ready", 32'(trans_ready_o), 32'd1);
        tick();
        drive(1'b1, 32'h18, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("c_ready_full", 32'(trans_ready_o), 32'd0);
        check_eq("c_req_full",   32'(obi_req_o),     32'd0);
        check_eq("c_outst",      32'(outstanding_o), 32'd2);
        tick();
        drive(1'b1, 32'h18, 1'b1, 1'b1, 32'hAAAA_0010, 1'b0);
        check_eq("d_ready_still_full", 32'(trans_ready_o), 32'd0);
        check_eq("d_resp_valid",       32'(resp_valid_o),  32'd1);
        check_eq("d_resp_rdata",       resp_rdata_o,       32'hAAAA_0010);
        tick();
        drive(1'b1, 32'h18, 1'b1, 1'b1, 32'hAAAA_0014, 1'b0);
        check_eq("e_ready_resumed", 32'(trans_ready_o), 32'd1);
        check_eq("e_req",           32'(obi_req_o),     32'd1);
        check_eq("e_addr",          obi_addr_o,         32'h18);
        check_eq("e_resp_rdata",    resp_rdata_o,       32'hAAAA_0014);
        tick();
        check_eq("gnt_rvalid_same_cycle_cnt", 32'(outstanding_o), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0018, 1'b0);
        check_eq("f_resp_valid", 32'(resp_valid_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("f_idle", 32'(idle_o), 32'd1);

        // Stalled grant: address held from the register while the requester changes its address
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_req0",  32'(obi_req_o), 32'd1);
        check_eq("stall_addr0", obi_addr_o,     32'h100);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
            check_eq("stall_req",   32'(obi_req_o),     32'd1);
            check_eq("stall_addr",  obi_addr_o,         32'h100);
            check_eq("stall_ready", 32'(trans_ready_o), 32'd0);
            tick();
        end
        drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("stall_gnt_addr", obi_addr_o, 32'h100);
        check_eq("stall_idle",     32'(idle_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_outst", 32'(outstanding_o), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB_0100, 1'b0);
        check_eq("stall_resp", 32'(resp_valid_o), 32'd1);
        tick();

        // Kill with two outstanding: both old responses dropped, new fetch delivered
        drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h304, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("kill_ready", 32'(trans_ready_o), 32'd0);
        check_eq("kill_req",   32'(obi_req_o),     32'd0);
        tick();
        drive(1'b1, 32'h400, 1'b1, 1'b1, 32'hDEAD_0300, 1'b0);
        check_eq("drop1_resp_valid", 32'(resp_valid_o), 32'd0);
        tick();
        drive(1'b1, 32'h400, 1'b1, 1'b1, 32'hDEAD_0304, 1'b0);
        check_eq("drop2_resp_valid", 32'(resp_valid_o), 32'd0);
        check_eq("new_req",          32'(obi_req_o),    32'd1);
        check_eq("new_addr",         obi_addr_o,        32'h400);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_0400, 1'b0);
        check_eq("new_resp_valid", 32'(resp_valid_o), 32'd1);
        check_eq("new_resp_rdata", resp_rdata_o,      32'h1234_0400);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("kill_idle", 32'(idle_o), 32'd1);

        // Kill while the request is still ungranted
        drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("kreg_req_held", 32'(obi_req_o), 32'd1);
        check_eq("kreg_addr",     obi_addr_o,     32'h500);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("kreg_pend_idle", 32'(idle_o),    32'd0);
        check_eq("kreg_req_still", 32'(obi_req_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("kreg_outst", 32'(outstanding_o), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0500, 1'b0);
        check_eq("kreg_drop", 32'(resp_valid_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("kreg_idle", 32'(idle_o), 32'd1);
        drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5678_0600, 1'b0);
        check_eq("kreg_after_resp", 32'(resp_valid_o), 32'd1);
        tick();

        // Reset mid-flight with one granted and one stalled request
        drive(1'b1, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h704, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("pre_rst_idle", 32'(idle_o), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("mid_rst_outst", 32'(outstanding_o), 32'd0);
        check_eq("mid_rst_idle",  32'(idle_o),        32'd1);
        check_eq("mid_rst_req",   32'(obi_req_o),     32'd0);
        check_eq("mid_rst_ready", 32'(trans_ready_o), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
